mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port data/instruction RAM between the instruction-fetch stage and the MEM stage of the five-stage pipeline. It sequences each access through a req/ready handshake with the RAM and returns read data and a one-cycle done pulse to the winning requester. It also drives stall signals that freeze the pipeline registers (IF/ID through EX/MEM) while an access is pending. The MEM stage has priority, bounded by a starvation limit for fetch.

## Interface
- STREAK_MAX, 4: max consecutive MEM grants while IF waits; range 1..7
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- mem_read  in  1  MEM-stage read request (EX/MEM MemRead), level
- mem_write  in  1  MEM-stage write request (EX/MEM MemWrite), level
- mem_addr  in  32  MEM-stage address (EX/MEM ALU result)
- mem_wdata  in  32  store data (EX/MEM ReadData2)
- mem_rdata  out  32  load data, valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse for MEM stage
- ram_req  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid with ram_ready
- ram_ready  in  1  RAM access complete
- stall_mem  out  1  freeze EX/MEM and all earlier pipeline registers
- stall_if  out  1  freeze PC and IF/ID
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, BUSY_M, BUSY_I, DONE_M, DONE_I.
- A MEM request is active when mem_read or mem_write is high. If both are high, the access is a write (ram_we=1), and mem_rdata is don't-care.
- IDLE, arbitration:
  - MEM only -> BUSY_M; IF only -> BUSY_I.
  - Both requesting -> BUSY_M, unless streak == STREAK_MAX, then BUSY_I.
- At grant, the address, write data and we are captured into registers. ram_addr, ram_wdata and ram_we come only from these registers and are stable for the whole access.
- BUSY_x: ram_req=1. On ram_ready=1 the FSM moves to DONE_x, registering ram_rdata into x_rdata.
- DONE_x: x_done=1 for exactly one cycle, no request is sampled, then the FSM returns to IDLE. This prevents re-granting a request that the pipeline is about to retire.
- streak counter, 3 bits:
  - +1 on a MEM grant with if_req=1.
  - Cleared on an IF grant, or on a MEM grant with if_req=0.
  - Saturates at STREAK_MAX.
- stall_mem = MEM request active AND NOT mem_done (combinational).
- stall_if = (if_req AND NOT if_done) OR stall_mem.
- busy = state != IDLE.
- x_rdata holds its last value outside DONE_x.

## Timing
- Reset (asynchronous, any state including mid-access):
  - State and registers go to IDLE, streak=0.
  - ram_req, ram_we, if_done, mem_done, busy are 0.
  - ram_addr, ram_wdata, if_rdata, mem_rdata are 0.
  - Any in-flight RAM access is abandoned. ram_req drops immediately, and the RAM must tolerate this.
- Access sequence, request seen in IDLE at cycle T:
  - Cycle T+1: BUSY with ram_req=1.
  - If ram_ready=1 in T+1+W, then x_done=1 in T+2+W.
  - IDLE again in T+3+W.
  - Minimum 3 cycles per access (W=0).
- Back-to-back: a request still high in the IDLE cycle after DONE is treated as a new access.
- ram_ready is ignored outside BUSY states.
- A request dropping mid-BUSY does not abort the access. The access completes, and done pulses regardless.
- Requests must not change address or data while held. This is not checked, since operands are captured at grant.

## Test plan
- Single load: mem_read=1, mem_addr=0x40, ram_ready high one cycle after ram_req, ram_rdata=0xDEADBEEF -> ram_addr=0x40, ram_we=0; mem_done pulses at T+2 with mem_rdata=0xDEADBEEF; stall_mem high T..T+1, low at T+2.
- Store with wait states: mem_write=1, addr=0x80, wdata=0x12345678, ram_ready delayed 3 cycles -> ram_req held 4 cycles with stable addr and data; ram_we=1; mem_done at T+5.
- Contention and starvation: IF and MEM requests held continuously, STREAK_MAX=4, ready after 1 cycle -> grant order M,M,M,M,I,M,...; if_done never starved beyond 4 MEM accesses.
- Read+write both asserted: mem_read=mem_write=1 -> ram_we=1, single access, one mem_done.
- Reset mid-access: assert reset during BUSY_I with ram_req=1 -> ram_req, busy, if_done are 0 in the same cycle; after release, with if_req still high, a new fetch starts from IDLE with streak=0.
- Spurious ready: ram_ready=1 in IDLE and DONE states -> no done pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundle of the fetch-side, MEM-side, RAM-side and stall signals
//             around the shared instruction/data RAM port.
//  Modports : master - arbiter view (drives done/rdata, RAM strobe, stalls)
//             slave  - environment view (pipeline stages and the RAM)
//  Signals  : if_req/if_addr/if_rdata/if_done        fetch requester
//             mem_read/mem_write/mem_addr/mem_wdata/
//             mem_rdata/mem_done                     MEM-stage requester
//             ram_req/ram_we/ram_addr/ram_wdata/
//             ram_rdata/ram_ready                    single-port RAM
//             stall_mem/stall_if/busy                pipeline control
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  logic        stall_mem;
  logic        stall_if;
  logic        busy;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_done,
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ready,
    output stall_mem, stall_if, busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_done,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ready,
    input  stall_mem, stall_if, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port RAM between instruction fetch and the
//             MEM stage. MEM has priority; fetch is guaranteed a grant after
//             STREAK_MAX consecutive MEM grants while it waits. Each access is
//             IDLE -> BUSY_x -> DONE_x -> IDLE (3 cycles minimum).
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous, active-high
//             bus   - mem_port_arbiter_if.master (fetch, MEM, RAM, stalls)
//  Params   : STREAK_MAX - max consecutive MEM grants while fetch waits (1..7)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STREAK_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [2:0] c_STREAK_MAX = 3'(STREAK_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_M = 3'd1,
    S_BUSY_I = 3'd2,
    S_DONE_M = 3'd3,
    S_DONE_I = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_streak;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;

  logic        w_mem_act;
  logic        w_grant_m;
  logic        w_grant_i;
  logic        w_ram_req;
  logic        w_if_done;
  logic        w_mem_done;
  logic        w_busy;
  logic        w_stall_mem;

  // A write wins when both MemRead and MemWrite are asserted.
  assign w_mem_act = bus.mem_read | bus.mem_write;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    w_grant_m  = 1'b0;
    w_grant_i  = 1'b0;
    w_ram_req  = 1'b0;
    w_if_done  = 1'b0;
    w_mem_done = 1'b0;
    w_busy     = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        // MEM wins unless fetch is waiting and has already been passed over
        // STREAK_MAX times in a row.
        if (w_mem_act && !(bus.if_req && (r_streak == c_STREAK_MAX))) begin
          w_grant_m = 1'b1;
          w_next    = S_BUSY_M;
        end else if (bus.if_req) begin
          w_grant_i = 1'b1;
          w_next    = S_BUSY_I;
        end
      end
      S_BUSY_M: begin
        w_ram_req = 1'b1;
        if (bus.ram_ready) w_next = S_DONE_M;
      end
      S_BUSY_I: begin
        w_ram_req = 1'b1;
        if (bus.ram_ready) w_next = S_DONE_I;
      end
      // DONE samples no request: the requester is retiring this cycle and
      // must not be granted a second time.
      S_DONE_M: begin
        w_mem_done = 1'b1;
        w_next     = S_IDLE;
      end
      S_DONE_I: begin
        w_if_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operands are captured at grant so the RAM sees stable values for the
  // whole access regardless of what the requesters do meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
    end else if (w_grant_m) begin
      r_addr  <= bus.mem_addr;
      r_wdata <= bus.mem_wdata;
      r_we    <= bus.mem_write;
    end else if (w_grant_i) begin
      r_addr  <= bus.if_addr;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
    end
  end

  // Read data registers hold their value until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      if ((r_state == S_BUSY_M) && bus.ram_ready) r_mem_rdata <= bus.ram_rdata;
      if ((r_state == S_BUSY_I) && bus.ram_ready) r_if_rdata  <= bus.ram_rdata;
    end
  end

  // Counts MEM grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= 3'd0;
    end else if (w_grant_i) begin
      r_streak <= 3'd0;
    end else if (w_grant_m) begin
      if (!bus.if_req) begin
        r_streak <= 3'd0;
      end else if (r_streak != c_STREAK_MAX) begin
        r_streak <= r_streak + 3'd1;
      end
    end
  end

  assign w_stall_mem   = w_mem_act & ~w_mem_done;

  assign bus.ram_req   = w_ram_req;
  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.if_done   = w_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_done  = w_mem_done;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.busy      = w_busy;
  assign bus.stall_mem = w_stall_mem;
  assign bus.stall_if  = (bus.if_req & ~w_if_done) | w_stall_mem;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter with a latency-
//             programmable RAM model and a completion scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STREAK_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // RAM model: answers ram_req after ram_wait extra cycles.
  logic [31:0] ram_mem [logic [31:0]];
  int ram_wait = 0;
  int ram_cnt  = 0;
  bit force_ready = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      bus.ram_ready = 1'b0;
      ram_cnt = 0;
    end else if (force_ready) begin
      bus.ram_ready = 1'b1;
    end else if (bus.ram_req && ram_cnt >= ram_wait) begin
      bus.ram_ready = 1'b1;
      bus.ram_rdata = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : 32'd0;
      if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
      ram_cnt = 0;
    end else begin
      bus.ram_ready = 1'b0;
      if (bus.ram_req) ram_cnt++;
      else ram_cnt = 0;
    end
  end

  // Advance to the next sample point (1 time unit after the falling edge).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.if_req = 0; bus.if_addr = 0;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    bus.ram_rdata = 0; bus.ram_ready = 0;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.ram_req, bus.ram_we, bus.if_done, bus.mem_done, bus.busy, bus.stall_if, bus.stall_mem} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {bus.ram_req, bus.ram_we, bus.if_done, bus.mem_done, bus.busy, bus.stall_if, bus.stall_mem});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_wdata, bus.if_rdata, bus.mem_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h mem_rdata=%h, expected all 0",
               bus.ram_addr, bus.ram_wdata, bus.if_rdata, bus.mem_rdata);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_single_load();
    exp_t e;
    ram_mem[32'h40] = 32'hDEADBEEF;
    ram_wait = 0;
    bus.mem_read = 1; bus.mem_addr = 32'h40;    // cycle T
    #1;
    checks++;
    if (bus.stall_mem !== 1'b1) begin
      errors++; $display("FAIL load_stall_T: stall_mem=%b expected 1", bus.stall_mem);
    end
    sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
    step();                                     // T+1
    checks++;
    if ({bus.ram_req, bus.ram_we, bus.ram_addr, bus.stall_mem, bus.mem_done} !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_busy: req=%b we=%b addr=%h stall=%b done=%b expected 1 0 00000040 1 0",
               bus.ram_req, bus.ram_we, bus.ram_addr, bus.stall_mem, bus.mem_done);
    end
    step();                                     // T+2
    checks++;
    if ({bus.mem_done, bus.stall_mem} !== 2'b10) begin
      errors++;
      $display("FAIL load_done: done=%b stall_mem=%b expected 1 0", bus.mem_done, bus.stall_mem);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.mem_rdata !== e.data) begin
        errors++; $display("FAIL load_rdata: got %h expected %h", bus.mem_rdata, e.data);
      end
    end
    bus.mem_read = 0;
    step();                                     // T+3
    checks++;
    if ({bus.busy, bus.mem_done, bus.mem_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL load_after: busy=%b done=%b rdata=%h expected 0 0 deadbeef",
               bus.busy, bus.mem_done, bus.mem_rdata);
    end
  endtask

  task automatic test_store_wait();
    ram_wait = 3;
    bus.mem_write = 1; bus.mem_addr = 32'h80; bus.mem_wdata = 32'h12345678;
    for (int i = 1; i <= 4; i++) begin
      step();                                   // T+1 .. T+4
      checks++;
      if ({bus.ram_req, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.mem_done} !==
          {1'b1, 1'b1, 32'h80, 32'h12345678, 1'b0}) begin
        errors++;
        $display("FAIL store_busy_%0d: req=%b we=%b addr=%h wdata=%h done=%b expected 1 1 00000080 12345678 0",
                 i, bus.ram_req, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.mem_done);
      end
    end
    step();                                     // T+5
    checks++;
    if ({bus.mem_done, bus.ram_req} !== 2'b10) begin
      errors++; $display("FAIL store_done: done=%b req=%b expected 1 0", bus.mem_done, bus.ram_req);
    end
    bus.mem_write = 0;
    step();
    checks++;
    if (ram_mem[32'h80] !== 32'h12345678) begin
      errors++; $display("FAIL store_data: ram[80]=%h expected 12345678", ram_mem[32'h80]);
    end
    ram_wait = 0;
  endtask

  task automatic test_contention();
    exp_t e;
    int got = 0;
    bit is_mem;
    ram_mem[32'h100] = 32'h11110000;
    ram_mem[32'h200] = 32'h22220000;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) sb.push_back('{1'b0, 1'b1, 32'h11110000});
      else              sb.push_back('{1'b1, 1'b1, 32'h22220000});
    end
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.mem_read = 1; bus.mem_addr = 32'h200;
    for (int c = 0; c < 60 && got < 10; c++) begin
      step();
      if (bus.if_done || bus.mem_done) begin
        is_mem = bus.mem_done;
        e = sb.pop_front();
        got++;
        checks++;
        if ({bus.mem_done, bus.if_done} !== {e.is_mem, !e.is_mem}) begin
          errors++;
          $display("FAIL contention_order_%0d: mem_done=%b if_done=%b expected mem=%b",
                   got, bus.mem_done, bus.if_done, e.is_mem);
        end
        checks++;
        if ((is_mem ? bus.mem_rdata : bus.if_rdata) !== e.data) begin
          errors++;
          $display("FAIL contention_data_%0d: got %h expected %h", got,
                   is_mem ? bus.mem_rdata : bus.if_rdata, e.data);
        end
        if (got == 10) begin
          bus.if_req = 0; bus.mem_read = 0;
        end
      end
    end
    checks++;
    if (got != 10) begin
      errors++; $display("FAIL contention_timeout: completions=%0d expected 10", got);
      bus.if_req = 0; bus.mem_read = 0;
      sb.delete();
    end
    step();
    step();
  endtask

  task automatic test_read_write();
    int dones = 0;
    bus.mem_read = 1; bus.mem_write = 1;
    bus.mem_addr = 32'h300; bus.mem_wdata = 32'hCAFEF00D;
    step();
    checks++;
    if ({bus.ram_req, bus.ram_we, bus.ram_wdata} !== {1'b1, 1'b1, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL rw_busy: req=%b we=%b wdata=%h expected 1 1 cafef00d",
               bus.ram_req, bus.ram_we, bus.ram_wdata);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.mem_done) begin
        dones++;
        bus.mem_read = 0; bus.mem_write = 0;
      end
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL rw_done_count: got %0d expected 1", dones);
    end
    checks++;
    if (ram_mem[32'h300] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rw_data: ram[300]=%h expected cafef00d", ram_mem[32'h300]);
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    bit seen = 1'b0;
    ram_mem[32'h500] = 32'h55AA55AA;
    ram_wait = 5;
    bus.if_req = 1; bus.if_addr = 32'h500;
    for (int c = 0; c < 5 && !seen; c++) begin
      step();
      if (bus.ram_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_mid_nobusy: ram_req=0 expected 1");
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.ram_req, bus.busy, bus.if_done, bus.ram_addr} !== {3'b000, 32'd0}) begin
      errors++;
      $display("FAIL rst_mid_async: req=%b busy=%b if_done=%b addr=%h expected 0 0 0 00000000",
               bus.ram_req, bus.busy, bus.if_done, bus.ram_addr);
    end
    step();
    step();
    ram_wait = 0;
    reset = 1'b0;
    sb.push_back('{1'b0, 1'b1, 32'h55AA55AA});
    step();
    checks++;
    if ({bus.ram_req, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 32'h500}) begin
      errors++;
      $display("FAIL rst_mid_refetch: req=%b we=%b addr=%h expected 1 0 00000500",
               bus.ram_req, bus.ram_we, bus.ram_addr);
    end
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step();
      if (bus.if_done) begin
        seen = 1'b1;
        e = sb.pop_front();
        checks++;
        if (bus.if_rdata !== e.data) begin
          errors++; $display("FAIL rst_mid_rdata: got %h expected %h", bus.if_rdata, e.data);
        end
        bus.if_req = 0;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_mid_timeout: if_done=0 expected 1");
      bus.if_req = 0;
      sb.delete();
    end
    step();
  endtask

  task automatic test_spurious_ready();
    force_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({bus.busy, bus.mem_done, bus.if_done} !== 3'b000) begin
        errors++;
        $display("FAIL spur_idle_%0d: busy=%b mem_done=%b if_done=%b expected 0 0 0",
                 c, bus.busy, bus.mem_done, bus.if_done);
      end
    end
    force_ready = 1'b0;
    step();
    bus.mem_read = 1; bus.mem_addr = 32'h40;    // T
    step();                                     // T+1, ready keeps high through DONE
    force_ready = 1'b1;
    step();                                     // T+2
    checks++;
    if ({bus.mem_done, bus.mem_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL spur_done: done=%b rdata=%h expected 1 deadbeef", bus.mem_done, bus.mem_rdata);
    end
    bus.mem_read = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({bus.busy, bus.mem_done, bus.ram_req} !== 3'b000) begin
        errors++;
        $display("FAIL spur_after_%0d: busy=%b done=%b req=%b expected 0 0 0",
                 c, bus.busy, bus.mem_done, bus.ram_req);
      end
    end
    force_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_wait();
    test_contention();
    test_read_write();
    test_reset_mid_access();
    test_spurious_ready();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
